vga_controller: RTL and testbench

Generates VGA raster timing and turns the one-bit `pixel_on` stream from the text reporter into sync and colour outputs. It sits directly upstream and downstream of the reporter: it drives the `hcounter`/`vcounter` the reporter uses for glyph lookup, then consumes the reporter's `pixel_on`. A built-in clock divider derives the pixel rate from the system clock. All outputs are realigned to the reporter's pipeline latency, so sync, blank and colour refer to the same pixel.

---
 rtl/vga_controller_pkg.sv | 31 +++
 rtl/vga_delay_line.sv | 42 ++++
 rtl/vga_controller.sv | 135 +++++++++++++
 tb/tb_vga_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_controller_pkg.sv
// Shared types and 640x480@60 timing defaults for the VGA raster controller and the blocks around
// it.
package vga_controller_pkg;

  localparam int unsigned CntW = 11;

  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  // One pixel's worth of raw timing, carried down the latency-matching delay line.
  typedef struct packed {
    logic blank;
    logic hact;
    logic vact;
  } timing_t;

  localparam timing_t IdleTiming = '{blank: 1'b1, hact: 1'b0, vact: 1'b0};

  function automatic logic in_window(input logic [CntW-1:0] x,
                                     input logic [CntW-1:0] lo,
                                     input logic [CntW-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with an asynchronous reset value; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned       Depth    = 1,
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [Depth-1:0][Width-1:0] stage_d, stage_q;

    always_comb begin
      stage_d = stage_q;
      if (en_i) begin
        stage_d[0] = d_i;
        for (int i = 1; i < Depth; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= {Depth{ResetVal}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_controller.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync/blank decode delayed to line
// up with the reporter's pixel_on, and registered sync/blank/colour outputs.
module vga_controller
  import vga_controller_pkg::*;
#(
  parameter int unsigned HVISIBLE    = DefHVisible,
  parameter int unsigned HFRONT      = DefHFront,
  parameter int unsigned HSYNC       = DefHSync,
  parameter int unsigned HBACK       = DefHBack,
  parameter int unsigned VVISIBLE    = DefVVisible,
  parameter int unsigned VFRONT      = DefVFront,
  parameter int unsigned VSYNC       = DefVSync,
  parameter int unsigned VBACK       = DefVBack,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned PIX_LATENCY = 1,
  parameter logic        SYNC_POL    = 1'b0,
  parameter logic [7:0]  FG_COLOR    = 8'hFF,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pixel_on,
  output logic [CntW-1:0] hcounter,
  output logic [CntW-1:0] vcounter,
  output logic            pix_en,
  output logic            frame_start,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output logic [7:0]      rgb
);

  localparam int unsigned HTOTAL = HVISIBLE + HFRONT + HSYNC + HBACK;
  localparam int unsigned VTOTAL = VVISIBLE + VFRONT + VSYNC + VBACK;

  localparam logic [CntW-1:0] HVis     = CntW'(HVISIBLE);
  localparam logic [CntW-1:0] HSyncLo  = CntW'(HVISIBLE + HFRONT);
  localparam logic [CntW-1:0] HSyncHi  = CntW'(HVISIBLE + HFRONT + HSYNC);
  localparam logic [CntW-1:0] HLast    = CntW'(HTOTAL - 1);
  localparam logic [CntW-1:0] VVis     = CntW'(VVISIBLE);
  localparam logic [CntW-1:0] VSyncLo  = CntW'(VVISIBLE + VFRONT);
  localparam logic [CntW-1:0] VSyncHi  = CntW'(VVISIBLE + VFRONT + VSYNC);
  localparam logic [CntW-1:0] VLast    = CntW'(VTOTAL - 1);

  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_d, div_q;
  logic [CntW-1:0] h_d, h_q, v_d, v_q;
  logic            frame_start_d, frame_start_q;
  logic            hsync_d, hsync_q, vsync_d, vsync_q, blank_d, blank_q;
  logic [7:0]      rgb_d, rgb_q;
  timing_t         raw, dly;

  // Gated by rst so the strobe is never seen while the block is held in reset.
  assign pix_en = rst && (div_q == DivLast);

  always_comb begin
    div_d         = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (h_q == HLast) begin
        h_d           = '0;
        v_d           = (v_q == VLast) ? '0 : v_q + CntW'(1);
        frame_start_d = (v_q == VLast);
      end else begin
        h_d = h_q + CntW'(1);
      end
    end
  end

  always_comb begin
    raw.blank = (h_q >= HVis) || (v_q >= VVis);
    raw.hact  = in_window(h_q, HSyncLo, HSyncHi);
    raw.vact  = in_window(v_q, VSyncLo, VSyncHi);
  end

  vga_delay_line #(
    .Depth    (PIX_LATENCY),
    .Width    ($bits(timing_t)),
    .ResetVal (IdleTiming)
  ) u_delay (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (pix_en),
    .d_i    (raw),
    .q_o    (dly)
  );

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      hsync_d = dly.hact ? SYNC_POL : ~SYNC_POL;
      vsync_d = dly.vact ? SYNC_POL : ~SYNC_POL;
      blank_d = dly.blank;
      rgb_d   = dly.blank ? 8'h00 : (pixel_on ? FG_COLOR : BG_COLOR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b1;
      rgb_q         <= 8'h00;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hcounter    = h_q;
  assign vcounter    = v_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_controller.sv
// Randomised bench for vga_controller: three small-raster instances checked every clock against a
// closed-form timing model driven by the clock count since reset release.
module tb_vga_controller;

  typedef struct packed {
    int         hv, hf, hs, hb, vv, vf, vs, vb, div, lat;
    logic       pol;
    logic [7:0] fg, bg;
  } cfg_t;

  localparam cfg_t CA = '{hv: 16, hf: 4, hs: 6, hb: 6, vv: 10, vf: 2, vs: 2, vb: 3,
                          div: 4, lat: 1, pol: 1'b0, fg: 8'hFF, bg: 8'h00};
  localparam cfg_t CB = '{hv: 12, hf: 3, hs: 5, hb: 4, vv: 8, vf: 1, vs: 2, vb: 2,
                          div: 1, lat: 0, pol: 1'b1, fg: 8'hE3, bg: 8'h1C};
  localparam cfg_t CC = '{hv: 20, hf: 2, hs: 3, hb: 5, vv: 6, vf: 2, vs: 1, vb: 2,
                          div: 2, lat: 3, pol: 1'b0, fg: 8'h5A, bg: 8'hA5};

  logic        clk, rst, rst_req;
  logic [2:0]  pon;
  logic [10:0] hc [3];
  logic [10:0] vc [3];
  logic        pe [3];
  logic        fs [3];
  logic        hs [3];
  logic        vs [3];
  logic        bl [3];
  logic [7:0]  rgb [3];

  int n, n_vec, n_err;
  bit hist [3][8192];

  vga_controller #(
    .HVISIBLE(CA.hv), .HFRONT(CA.hf), .HSYNC(CA.hs), .HBACK(CA.hb),
    .VVISIBLE(CA.vv), .VFRONT(CA.vf), .VSYNC(CA.vs), .VBACK(CA.vb),
    .CLK_DIV(CA.div), .PIX_LATENCY(CA.lat), .SYNC_POL(CA.pol),
    .FG_COLOR(CA.fg), .BG_COLOR(CA.bg)
  ) u_dut_a (
    .clk(clk), .rst(rst), .pixel_on(pon[0]), .hcounter(hc[0]), .vcounter(vc[0]),
    .pix_en(pe[0]), .frame_start(fs[0]), .hsync(hs[0]), .vsync(vs[0]), .blank(bl[0]),
    .rgb(rgb[0])
  );

  vga_controller #(
    .HVISIBLE(CB.hv), .HFRONT(CB.hf), .HSYNC(CB.hs), .HBACK(CB.hb),
    .VVISIBLE(CB.vv), .VFRONT(CB.vf), .VSYNC(CB.vs), .VBACK(CB.vb),
    .CLK_DIV(CB.div), .PIX_LATENCY(CB.lat), .SYNC_POL(CB.pol),
    .FG_COLOR(CB.fg), .BG_COLOR(CB.bg)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pixel_on(pon[1]), .hcounter(hc[1]), .vcounter(vc[1]),
    .pix_en(pe[1]), .frame_start(fs[1]), .hsync(hs[1]), .vsync(vs[1]), .blank(bl[1]),
    .rgb(rgb[1])
  );

  vga_controller #(
    .HVISIBLE(CC.hv), .HFRONT(CC.hf), .HSYNC(CC.hs), .HBACK(CC.hb),
    .VVISIBLE(CC.vv), .VFRONT(CC.vf), .VSYNC(CC.vs), .VBACK(CC.vb),
    .CLK_DIV(CC.div), .PIX_LATENCY(CC.lat), .SYNC_POL(CC.pol),
    .FG_COLOR(CC.fg), .BG_COLOR(CC.bg)
  ) u_dut_c (
    .clk(clk), .rst(rst), .pixel_on(pon[2]), .hcounter(hc[2]), .vcounter(vc[2]),
    .pix_en(pe[2]), .frame_start(fs[2]), .hsync(hs[2]), .vsync(vs[2]), .blank(bl[2]),
    .rgb(rgb[2])
  );

  always #5 clk = ~clk;

  function automatic cfg_t cfg_of(input int i);
    case (i)
      0:       return CA;
      1:       return CB;
      default: return CC;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (clk %0d after reset, t=%0t)",
               tag, got, exp, n, $time);
    end
  endtask

  // Expected state after n clock edges out of reset: s strobes done, the raster position is s mod
  // frame size, and the registered outputs describe the position from lat+1 strobes ago.
  task automatic check_dut(input int i);
    cfg_t  c;
    string nm;
    int    ht, vt, tot, s, p, k, hq, vq;
    logic  epe, efs, ehs, evs, ebl;
    logic [7:0] ergb;
    c   = cfg_of(i);
    nm  = (i == 0) ? "a" : (i == 1) ? "b" : "c";
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    tot = ht * vt;
    s   = n / c.div;
    p   = s % tot;
    epe = rst && (n % c.div == c.div - 1);
    efs = rst && (s > 0) && (s % tot == 0) && (n % c.div == 0);
    k   = s - 1 - c.lat;
    if (k < 0) begin
      ehs  = ~c.pol;
      evs  = ~c.pol;
      ebl  = 1'b1;
      ergb = 8'h00;
    end else begin
      hq   = (k % tot) % ht;
      vq   = (k % tot) / ht;
      ebl  = (hq >= c.hv) || (vq >= c.vv);
      ehs  = (hq >= c.hv + c.hf && hq < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
      evs  = (vq >= c.vv + c.vf && vq < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
      ergb = ebl ? 8'h00 : (hist[i][s] ? c.fg : c.bg);
    end
    check_val({nm, ".hcounter"},    32'(hc[i]),  32'(p % ht));
    check_val({nm, ".vcounter"},    32'(vc[i]),  32'(p / ht));
    check_val({nm, ".pix_en"},      32'(pe[i]),  32'(epe));
    check_val({nm, ".frame_start"}, 32'(fs[i]),  32'(efs));
    check_val({nm, ".hsync"},       32'(hs[i]),  32'(ehs));
    check_val({nm, ".vsync"},       32'(vs[i]),  32'(evs));
    check_val({nm, ".blank"},       32'(bl[i]),  32'(ebl));
    check_val({nm, ".rgb"},         32'(rgb[i]), 32'(ergb));
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) check_dut(i);
  endtask

  // One clock: check at the falling edge, apply any reset change, drive pixel_on, count the edge.
  task automatic tick(input bit all_on);
    cfg_t c;
    @(negedge clk);
    check_all();
    if (rst_req !== rst) begin
      rst = rst_req;
      if (!rst) begin
        n = 0;
        #1;
        check_all();
      end
    end
    for (int i = 0; i < 3; i++) begin
      c      = cfg_of(i);
      pon[i] = all_on ? 1'b1 : 1'($urandom);
      if (rst && ((n + 1) % c.div == 0)) hist[i][(n + 1) / c.div] = pon[i];
    end
    @(posedge clk);
    if (rst) n++;
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    rst_req = 1'b0;
    pon     = '0;
    n       = 0;
    n_vec   = 0;
    n_err   = 0;
    #1 rst = 1'b0;
    #1 check_all();
    repeat (3) tick(1'b0);
    rst_req = 1'b1;
    repeat (2200) tick(1'b0);
    repeat (600) tick(1'b1);
    // Drop reset somewhere mid-frame, then let everything restart from (0,0).
    repeat ($urandom_range(0, 40)) tick(1'b0);
    rst_req = 1'b0;
    repeat (4) tick(1'b0);
    rst_req = 1'b1;
    repeat (2400) tick(1'b0);
    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
